vga_sync_ctrl: RTL and testbench
================================

# vga_sync_ctrl

Timing controller that sequences the VGA image generator. It produces the pixel clock enable, the horizontal and vertical pixel counters, `bright`, and active-low `hsync`/`vsync` for 640x480 at 60 Hz. A run/drain state machine controls it so that scan-out only stops on a frame boundary. The `h_count`, `v_count` and `bright` outputs drive the image generator directly; `hsync` and `vsync` go to the connector.

## Interface
- `CLK_DIV`, default 2: `clk` cycles per pixel; 1 or greater.
- `H_FP`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: horizontal sync width, in pixels.
- `H_BP`, default 48: horizontal back porch, in pixels.
- `H_ACT`, default 640: visible pixels per line.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vertical sync width, in lines.
- `V_BP`, default 29: vertical back porch, in lines.
- `V_ACT`, default 480: visible lines per frame.
- `clk` in 1: system clock, the only clock.
- `rst_n` in 1: synchronous active-low reset; one clock; reset is synchronous and active-low.
- `run` in 1: level request to scan out.
- `pix_tick` out 1: high in the last `clk` cycle of each pixel period.
- `h_count` out 10: horizontal position, 0 to H_TOTAL-1.
- `v_count` out 10: vertical position, 0 to V_TOTAL-1.
- `bright` out 1: high in the visible region.
- `hsync` out 1: active-low horizontal sync.
- `vsync` out 1: active-low vertical sync.
- `frame_start` out 1: one-cycle pulse at the start of a frame.
- `busy` out 1: high when the state is not IDLE.

## Operation
- Derived constants:
  - H_TOTAL = H_FP+H_SYNC+H_BP+H_ACT = 800.
  - V_TOTAL = V_FP+V_SYNC+V_BP+V_ACT = 521.
  - Both must be 1024 or less; elaboration fails otherwise.
- Count order within a line: front porch, sync, back porch, visible.
  - `hsync` = 0 for `h_count` in [H_FP, H_FP+H_SYNC-1] = [16, 111].
  - The visible span is `h_count` in [160, 799].
- Vertical order is the same.
  - `vsync` = 0 for `v_count` in [10, 11].
  - The visible span is `v_count` in [41, 520].
- `bright` = (`h_count` ≥ 160) & (`v_count` ≥ 41) & `busy`.
- Divider:
  - `div_cnt` counts 0 to CLK_DIV-1 while `busy` is high and is held at 0 in IDLE.
  - `pix_tick` = `busy` & (`div_cnt` == CLK_DIV-1).
- Counter advance, on a clock edge where `pix_tick` is high:
  - `h_count` increments.
  - At H_TOTAL-1, `h_count` wraps to 0 and `v_count` increments.
  - `v_count` wraps to 0 after V_TOTAL-1.
- State machine:
  - IDLE: counters and `div_cnt` are held at 0; `hsync` = `vsync` = 1; `bright` = 0. If `run` = 1, go to RUN.
  - RUN: counters advance. If `run` = 0, go to DRAIN.
  - DRAIN: counters advance. If `run` = 1, return to RUN with no disturbance to the counts. On the tick where `h_count` = 799 and `v_count` = 520, go to IDLE; the counters become 0 on the same edge.
  - In RUN, the end of a frame simply wraps.
- `frame_start` = `pix_tick` & `busy` & (`h_count` == 0) & (`v_count` == 0).
  - It therefore also pulses on the first pixel after leaving IDLE.

## Timing
- Reset values, applied on the first edge with `rst_n` = 0:
  - state = IDLE;
  - `div_cnt`, `h_count`, `v_count` = 0;
  - `hsync` = `vsync` = 1;
  - `bright`, `pix_tick`, `frame_start`, `busy` = 0.
- Reset mid-frame takes priority over every other event; no drain occurs.
- Start latency:
  - `run` rises at edge N, so state = RUN and `busy` = 1 after edge N+1.
  - The first `pix_tick` occurs CLK_DIV-1 cycles later, with `h_count` = 0.
- Sync and bright decodes are combinational from the registered counters and state, so they align with `h_count`/`v_count` in the same cycle.
- Pixel period is CLK_DIV `clk` cycles; a frame is 800 × 521 × CLK_DIV cycles (833600 at the default).
- `run` falls and rises again within DRAIN: no gap and no extra `frame_start`.
- `run` falls on the final tick edge itself: DRAIN is not yet entered, so a full extra frame is scanned.

## Structure
- Package `vga_timing_pkg` holds:
  - the default porch, sync and active constants;
  - H_TOTAL and V_TOTAL;
  - the state encoding {IDLE, RUN, DRAIN}.
- Sub-module `vga_pix_div`:
  - clock-enable divider with CLK_DIV parameter;
  - inputs `clk`, `rst_n`, `en`; output `tick`;
  - `div_cnt` is cleared when `en` = 0.
- Counters, state machine and decodes stay in `vga_sync_ctrl`.

## Test plan
- **Reset values:** assert `rst_n` = 0 with `run` = 1 mid-frame → the next cycle shows all outputs at their reset values; `busy` = 0.
- **Sync windows (CLK_DIV = 2):** `run` held at 1 → `hsync` low for exactly 96 ticks (`h_count` 16 to 111) per line, and `vsync` low for exactly 2 lines (`v_count` 10, 11). The frame repeats every 833600 `clk` cycles, with one `frame_start` per frame.
- **Visible region:** count `bright` ticks per frame → exactly 307200, with the first at (160, 41) and the last at (799, 520).
- **Drain:** drop `run` at (300, 200) → the frame completes; `busy` falls on the edge after the tick at (799, 520); the counters read (0, 0) and `hsync` = `vsync` = 1.
- **Re-run during drain:** drop `run`, then raise it again before the frame ends → continuous counting; `frame_start` spacing stays at 833600 cycles.
- **CLK_DIV = 1:** `pix_tick` is high on every `busy` cycle; the frame is 416800 cycles; start latency is 1 cycle after `run` rises.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz) and the scan-control state encoding.
// Imported by the interface and the timing controller.
package vga_timing_pkg;
  localparam int CNT_W     = 10;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_H_ACT  = 640;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 29;
  localparam int DEF_V_ACT  = 480;
  localparam int H_TOTAL = DEF_H_FP + DEF_H_SYNC + DEF_H_BP + DEF_H_ACT;
  localparam int V_TOTAL = DEF_V_FP + DEF_V_SYNC + DEF_V_BP + DEF_V_ACT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/vga_sync_ctrl_if.sv
// Timing bundle between the sync controller (master) and the image generator (slave).
interface vga_sync_ctrl_if;
  import vga_timing_pkg::*;
  logic             run;
  logic             pix_tick;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             bright;
  logic             hsync;
  logic             vsync;
  logic             frame_start;
  logic             busy;

  modport master (input run, output pix_tick, h_count, v_count, bright,
                  hsync, vsync, frame_start, busy);
  modport slave  (output run, input pix_tick, h_count, v_count, bright,
                  hsync, vsync, frame_start, busy);
endinterface

// File: rtl/vga_pix_div.sv
// Pixel clock-enable divider: tick high in the last clk cycle of each pixel period.
module vga_pix_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_cnt;

  // Cleared while disabled so the first pixel after enable is a full period.
  always_ff @(posedge clk) begin
    if (!rst_n || !en)        div_cnt <= '0;
    else if (div_cnt == LAST) div_cnt <= '0;
    else                      div_cnt <= div_cnt + W'(1);
  end

  assign tick = en && (div_cnt == LAST);
endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA timing controller: pixel/line counters, sync/bright decodes and a run/drain
// FSM that only stops scan-out on a frame boundary.
module vga_sync_ctrl
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int H_ACT   = DEF_H_ACT,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP,
  parameter int V_ACT   = DEF_V_ACT
) (
  input logic            clk,
  input logic            rst_n,
  vga_sync_ctrl_if.master vga
);
  localparam int H_TOT = H_FP + H_SYNC + H_BP + H_ACT;
  localparam int V_TOT = V_FP + V_SYNC + V_BP + V_ACT;

  if (H_TOT > 1024 || V_TOT > 1024 || CLK_DIV < 1) begin : g_bad_timing
    $error("vga_sync_ctrl: totals must be <= 1024 and CLK_DIV >= 1");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_FP + H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_FP + V_SYNC + V_BP);

  state_t           state;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             busy, tick, eof;

  assign busy = (state != IDLE);

  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (busy),
    .tick (tick)
  );

  assign eof = tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // Counters only move on a tick, which never fires in IDLE, so IDLE holds 0;
  // the end-of-frame wrap is what leaves them at 0 when DRAIN drops to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end else begin
          h_cnt <= h_cnt + CNT_W'(1);
        end
      end
      case (state)
        IDLE:    if (vga.run) state <= RUN;
        RUN:     if (!vga.run) state <= DRAIN;
        DRAIN:   if (vga.run) state <= RUN;
                 else if (eof) state <= IDLE;
        default: begin
          state <= IDLE;
          h_cnt <= '0;
          v_cnt <= '0;
        end
      endcase
    end
  end

  assign vga.pix_tick    = tick;
  assign vga.h_count     = h_cnt;
  assign vga.v_count     = v_cnt;
  assign vga.busy        = busy;
  assign vga.hsync       = !(busy && (h_cnt >= HS_BEG) && (h_cnt <= HS_END));
  assign vga.vsync       = !(busy && (v_cnt >= VS_BEG) && (v_cnt <= VS_END));
  assign vga.bright      = busy && (h_cnt >= H_VIS) && (v_cnt >= V_VIS);
  assign vga.frame_start = tick && busy && (h_cnt == '0) && (v_cnt == '0);
endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Directed bench on a shrunken raster (15 x 8): dut_a at CLK_DIV=2, dut_b at CLK_DIV=1.
module tb_vga_sync_ctrl;
  // h: fp 0-1, sync 2-4, bp 5-6, vis 7-14 ; v: fp 0, sync 1-2, bp 3, vis 4-7
  localparam int HFP = 2, HSY = 3, HBP = 2, HAC = 8;
  localparam int VFP = 1, VSY = 2, VBP = 1, VAC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vga_sync_ctrl_if ifa ();
  vga_sync_ctrl_if ifb ();

  vga_sync_ctrl #(.CLK_DIV(2), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP), .H_ACT(HAC),
                  .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .V_ACT(VAC))
    dut_a (.clk(clk), .rst_n(rst_n), .vga(ifa));

  vga_sync_ctrl #(.CLK_DIV(1), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP), .H_ACT(HAC),
                  .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .V_ACT(VAC))
    dut_b (.clk(clk), .rst_n(rst_n), .vga(ifb));

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, ".busy"},  int'(ifa.busy), 0);
    chk({tag, ".h"},     int'(ifa.h_count), 0);
    chk({tag, ".v"},     int'(ifa.v_count), 0);
    chk({tag, ".hsync"}, int'(ifa.hsync), 1);
    chk({tag, ".vsync"}, int'(ifa.vsync), 1);
    chk({tag, ".bright"},int'(ifa.bright), 0);
    chk({tag, ".tick"},  int'(ifa.pix_tick), 0);
    chk({tag, ".fs"},    int'(ifa.frame_start), 0);
  endtask

  int hs_lo, vs_lo, br, fs_n, br_fh, br_fv, br_lh, br_lv, hs_min, hs_max, fs_last, fs_gap;

  task automatic scan_a(input int n);
    repeat (n) begin
      if (ifa.pix_tick) begin
        if (!ifa.hsync) begin
          hs_lo++;
          if (int'(ifa.h_count) < hs_min) hs_min = int'(ifa.h_count);
          if (int'(ifa.h_count) > hs_max) hs_max = int'(ifa.h_count);
        end
        if (!ifa.vsync) vs_lo++;
        if (ifa.bright) begin
          if (br == 0) begin br_fh = int'(ifa.h_count); br_fv = int'(ifa.v_count); end
          br_lh = int'(ifa.h_count); br_lv = int'(ifa.v_count);
          br++;
        end
      end
      if (ifa.frame_start) begin
        fs_n++;
        if (fs_last >= 0) fs_gap = cyc - fs_last;
        fs_last = cyc;
      end
      @(negedge clk);
    end
  endtask

  // Leaves the bench on the sample where dut_a ticks at (h, v).
  task automatic wait_pos_a(input string tag, input int h, input int v, input int budget);
    int found = 0;
    for (int i = 0; i < budget; i++) begin
      if (ifa.pix_tick && int'(ifa.h_count) == h && int'(ifa.v_count) == v) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, ".found"}, found, 1);
  endtask

  task automatic wait_fs_a(input string tag, input int budget, output int t);
    int found = 0;
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ifa.frame_start) begin found = 1; t = cyc; break; end
    end
    chk({tag, ".found"}, found, 1);
  endtask

  initial begin
    int n, lh, lv, fsd, t1, t2, tb1, tb2, tk, fb;
    ifa.run = 1'b0;
    ifb.run = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);

    // reset holds idle even with run requested
    ifa.run = 1'b1;
    @(negedge clk);
    chk_idle_a("rst0");

    // start latency: busy one edge after run, first tick CLK_DIV-1 later at (0,0)
    ifa.run = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("idle.busy", int'(ifa.busy), 0);
    ifa.run = 1'b1;
    @(negedge clk);
    chk("start.busy", int'(ifa.busy), 1);
    chk("start.tick0", int'(ifa.pix_tick), 0);
    @(negedge clk);
    chk("start.tick1", int'(ifa.pix_tick), 1);
    chk("start.fs", int'(ifa.frame_start), 1);
    chk("start.h", int'(ifa.h_count), 0);
    chk("start.v", int'(ifa.v_count), 0);

    // one full frame of statistics, then a second frame for the period
    hs_lo = 0; vs_lo = 0; br = 0; fs_n = 0; hs_min = 9999; hs_max = -1;
    br_fh = -1; br_fv = -1; br_lh = -1; br_lv = -1; fs_last = -1; fs_gap = -1;
    scan_a(240);
    chk("frm.hs_lo", hs_lo, 24);
    chk("frm.hs_min", hs_min, 2);
    chk("frm.hs_max", hs_max, 4);
    chk("frm.vs_lo", vs_lo, 30);
    chk("frm.bright", br, 32);
    chk("frm.br_fh", br_fh, 7);
    chk("frm.br_fv", br_fv, 4);
    chk("frm.br_lh", br_lh, 14);
    chk("frm.br_lv", br_lv, 7);
    chk("frm.fs", fs_n, 1);
    scan_a(240);
    chk("frm2.fs", fs_n, 2);
    chk("frm2.gap", fs_gap, 240);

    // drain from (5,3): 69 more ticks, busy drops one cycle after the last
    wait_pos_a("drain.pos", 5, 3, 300);
    ifa.run = 1'b0;
    n = 0; lh = -1; lv = -1; fsd = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (!ifa.busy) break;
      if (ifa.pix_tick) begin lh = int'(ifa.h_count); lv = int'(ifa.v_count); end
      if (ifa.frame_start) fsd++;
    end
    chk("drain.cycles", n, 139);
    chk("drain.last_h", lh, 14);
    chk("drain.last_v", lv, 7);
    chk("drain.fs", fsd, 0);
    chk_idle_a("drain.end");

    // re-run during drain: counting is continuous, frame period unchanged
    ifa.run = 1'b1;
    wait_fs_a("rerun.fs1", 10, t1);
    wait_pos_a("rerun.pos", 3, 2, 300);
    ifa.run = 1'b0;
    repeat (20) @(negedge clk);
    chk("rerun.busy", int'(ifa.busy), 1);
    ifa.run = 1'b1;
    wait_fs_a("rerun.fs2", 400, t2);
    chk("rerun.gap", t2 - t1, 240);

    // CLK_DIV=1: tick on every busy cycle, first tick right after run is seen
    ifb.run = 1'b1;
    @(negedge clk);
    chk("b.busy", int'(ifb.busy), 1);
    chk("b.tick", int'(ifb.pix_tick), 1);
    chk("b.fs", int'(ifb.frame_start), 1);
    tb1 = cyc;
    tk = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ifb.pix_tick) tk++;
    end
    chk("b.ticks", tk, 50);
    chk("b.h", int'(ifb.h_count), 5);
    chk("b.v", int'(ifb.v_count), 3);
    fb = 0; tb2 = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifb.frame_start) begin fb = 1; tb2 = cyc; break; end
    end
    chk("b.fs2.found", fb, 1);
    chk("b.gap", tb2 - tb1, 120);

    // reset mid-frame wins over run; no drain
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_a("rst_mid");
    chk("rst_mid.b_busy", int'(ifb.busy), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
